// File: rtl/pwm_softstart_ctrl.sv
// Soft-start, slew-limit and ramp-down sequencer driving the half-bridge PWM generator.
// Duty only moves on carrier update events, so the PWM never sees a mid-period change.
module pwm_softstart_ctrl #(
  parameter int WIDTH    = 32,
  parameter int STEP_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             fault,
  input  logic             fault_clr,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] duty_target,
  input  logic [WIDTH-1:0] duty_step,
  input  logic             update_sel,
  input  logic             f_zero,
  input  logic             f_period,
  output logic             pwm_on,
  output logic [WIDTH-1:0] duty_cycle,
  output logic [2:0]       state,
  output logic             running,
  output logic             fault_latched
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARM       = 3'd1,
    S_RAMP_UP   = 3'd2,
    S_RUN       = 3'd3,
    S_RAMP_DOWN = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  localparam int               DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  // One extra bit on additions so large duty/step values never wrap.
  function automatic logic [WIDTH:0] wide_add(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  function automatic logic [WIDTH-1:0] slew(input logic [WIDTH-1:0] cur,
                                            input logic [WIDTH-1:0] tgt_v,
                                            input logic [WIDTH-1:0] stp_v);
    logic [WIDTH:0]   up;
    logic [WIDTH-1:0] dn;
    logic [WIDTH-1:0] res;
    up  = wide_add(cur, stp_v);
    dn  = sat_sub(cur, stp_v);
    res = cur;
    if (cur < tgt_v)
      res = (up >= {1'b0, tgt_v}) ? tgt_v : up[WIDTH-1:0];
    else if (cur > tgt_v)
      res = (dn <= tgt_v) ? tgt_v : dn;
    return res;
  endfunction

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] duty_nxt;
  logic             pwm_nxt;
  logic [DIV_W-1:0] div_q, div_nxt;
  logic             upd, tick;
  logic [WIDTH-1:0] tgt, stp;
  logic [WIDTH:0]   sum;

  assign upd   = f_zero | (update_sel & f_period);
  assign tick  = upd & (div_q == DIV_LAST);
  assign tgt   = (duty_target > period) ? period : duty_target;
  assign stp   = (duty_step == '0) ? WIDTH'(1) : duty_step;
  assign sum   = wide_add(duty_cycle, stp);
  assign state = state_q;

  always_comb begin
    state_nxt = state_q;
    duty_nxt  = duty_cycle;
    pwm_nxt   = pwm_on;
    div_nxt   = div_q;
    if (upd)
      div_nxt = tick ? '0 : div_q + DIV_W'(1);

    if (fault) begin
      state_nxt = S_FAULT;
      pwm_nxt   = 1'b0;
      duty_nxt  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !stop) begin
            state_nxt = S_ARM;
            div_nxt   = '0;
          end
        end
        S_ARM: begin
          if (stop) begin
            state_nxt = S_IDLE;
          end else if (upd) begin
            state_nxt = S_RAMP_UP;
            pwm_nxt   = 1'b1;
            duty_nxt  = '0;
          end
        end
        S_RAMP_UP: begin
          if (stop) begin
            state_nxt = S_RAMP_DOWN;
          end else if (tick) begin
            if (sum >= {1'b0, tgt}) begin
              duty_nxt  = tgt;
              state_nxt = S_RUN;
            end else begin
              duty_nxt = sum[WIDTH-1:0];
            end
          end
        end
        S_RUN: begin
          if (stop)
            state_nxt = S_RAMP_DOWN;
          else if (tick)
            duty_nxt = slew(duty_cycle, tgt, stp);
        end
        S_RAMP_DOWN: begin
          // The tick that finds duty already at 0 is the one that turns the bridge off.
          if (tick) begin
            if (duty_cycle == '0) begin
              pwm_nxt   = 1'b0;
              state_nxt = S_IDLE;
            end else begin
              duty_nxt = sat_sub(duty_cycle, stp);
            end
          end
        end
        S_FAULT: begin
          if (fault_clr)
            state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      duty_cycle    <= '0;
      pwm_on        <= 1'b0;
      div_q         <= '0;
      running       <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      duty_cycle    <= duty_nxt;
      pwm_on        <= pwm_nxt;
      div_q         <= div_nxt;
      running       <= (state_nxt == S_RUN);
      fault_latched <= (state_nxt == S_FAULT);
    end
  end

endmodule

// File: tb/tb_pwm_softstart_ctrl.sv
// Scoreboard bench for pwm_softstart_ctrl: a 32-bit/STEP_DIV=1 and an 8-bit/STEP_DIV=2
// instance share stimulus; each is checked every cycle against its own reference model.
module tb_pwm_softstart_ctrl;

  localparam int W2 = 8;

  logic        clk = 1'b0;
  logic        rst, start, stop, fault, fault_clr, update_sel, f_zero, f_period;
  logic [31:0] period, duty_target, duty_step;

  logic        pwm_on1, running1, fault1;
  logic [31:0] duty1;
  logic [2:0]  state1;
  logic        pwm_on2, running2, fault2;
  logic [W2-1:0] duty2;
  logic [2:0]  state2;

  always #5 clk = ~clk;

  pwm_softstart_ctrl #(.WIDTH(32), .STEP_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .fault(fault), .fault_clr(fault_clr),
    .period(period), .duty_target(duty_target), .duty_step(duty_step),
    .update_sel(update_sel), .f_zero(f_zero), .f_period(f_period),
    .pwm_on(pwm_on1), .duty_cycle(duty1), .state(state1),
    .running(running1), .fault_latched(fault1)
  );

  pwm_softstart_ctrl #(.WIDTH(W2), .STEP_DIV(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .fault(fault), .fault_clr(fault_clr),
    .period(period[W2-1:0]), .duty_target(duty_target[W2-1:0]), .duty_step(duty_step[W2-1:0]),
    .update_sel(update_sel), .f_zero(f_zero), .f_period(f_period),
    .pwm_on(pwm_on2), .duty_cycle(duty2), .state(state2),
    .running(running2), .fault_latched(fault2)
  );

  typedef struct packed {
    int     st;
    longint duty;
    bit     pwm;
    int     div;
  } mdl_t;

  typedef struct packed {
    bit rst, start, stop, fault, fclr, usel, fz, fp;
    longint per, tgt, stp;
  } in_t;

  mdl_t   m1, m2;
  mdl_t   q1[$], q2[$];
  longint rec1[$], rec2[$];
  longint last1, last2;
  int     car, car_len;
  int     checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference model: one clock of the sequencer rules on plain integers.
  function automatic mdl_t model_next(input mdl_t m, input in_t i, input int w, input int sd);
    mdl_t   n;
    longint mask, per, tg, stp, d;
    bit     upd, tk;
    n = m;
    if (i.rst) begin
      n = '0;
      return n;
    end
    mask = (longint'(1) << w) - 1;
    per  = i.per & mask;
    tg   = i.tgt & mask;
    if (tg > per) tg = per;
    stp  = i.stp & mask;
    if (stp == 0) stp = 1;
    d    = m.duty;
    upd  = i.fz | (i.usel & i.fp);
    tk   = upd && (m.div == sd - 1);
    if (upd) n.div = tk ? 0 : m.div + 1;
    if (i.fault) begin
      n.st = 5; n.pwm = 1'b0; n.duty = 0;
      return n;
    end
    case (m.st)
      0: if (i.start && !i.stop) begin n.st = 1; n.div = 0; end
      1: if (i.stop) n.st = 0;
         else if (upd) begin n.st = 2; n.pwm = 1'b1; n.duty = 0; end
      2: if (i.stop) n.st = 4;
         else if (tk) begin
           if (d + stp >= tg) begin n.duty = tg; n.st = 3; end
           else n.duty = d + stp;
         end
      3: if (i.stop) n.st = 4;
         else if (tk) begin
           if (d < tg) n.duty = (d + stp < tg) ? d + stp : tg;
           else if (d > tg) n.duty = (d - stp > tg) ? d - stp : tg;
         end
      4: if (tk) begin
           if (d == 0) begin n.pwm = 1'b0; n.st = 0; end
           else n.duty = (d > stp) ? d - stp : 0;
         end
      5: if (i.fclr) n.st = 0;
      default: ;
    endcase
    return n;
  endfunction

  // Inputs are set at the falling edge; the model predicts the state after the next rising edge.
  task automatic cyc();
    in_t i;
    f_zero   = (car == 0);
    f_period = (car == car_len / 2);
    car      = (car + 1 >= car_len) ? 0 : car + 1;
    i.rst = rst; i.start = start; i.stop = stop; i.fault = fault; i.fclr = fault_clr;
    i.usel = update_sel; i.fz = f_zero; i.fp = f_period;
    i.per = longint'(period); i.tgt = longint'(duty_target); i.stp = longint'(duty_step);
    m1 = model_next(m1, i, 32, 1); q1.push_back(m1);
    m2 = model_next(m2, i, W2, 2); q2.push_back(m2);
    @(negedge clk);
    if (longint'(duty1) != last1) begin rec1.push_back(longint'(duty1)); last1 = longint'(duty1); end
    if (longint'(duty2) != last2) begin rec2.push_back(longint'(duty2)); last2 = longint'(duty2); end
  endtask

  task automatic rec_clear();
    rec1.delete(); rec2.delete();
    last1 = longint'(duty1); last2 = longint'(duty2);
  endtask

  task automatic run_until(input int st_want, input int max_cyc, input string name);
    for (int k = 0; k < max_cyc && !(m1.st == st_want && m2.st == st_want); k++) cyc();
    chk({name, "_dut1_state"}, 64'(state1), 64'(st_want));
    chk({name, "_dut2_state"}, 64'(state2), 64'(st_want));
  endtask

  task automatic cmp_seq(input string name, input int which, input longint exp[4], input int n);
    longint got[$];
    got = (which == 1) ? rec1 : rec2;
    chk($sformatf("%s_len", name), 64'(got.size()), 64'(n));
    for (int k = 0; k < n; k++)
      if (k < got.size()) chk($sformatf("%s_%0d", name, k), 64'(got[k]), 64'(exp[k]));
  endtask

  // Monitor: pops one expectation per DUT each cycle, just after the rising edge.
  initial begin
    mdl_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("dut1_outputs", {26'd0, state1, duty1, pwm_on1, running1, fault1},
            {26'd0, 3'(e.st), e.duty[31:0], e.pwm, e.st == 3, e.st == 5});
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        chk("dut2_outputs", {26'd0, state2, 32'(duty2), pwm_on2, running2, fault2},
            {26'd0, 3'(e.st), e.duty[31:0], e.pwm, e.st == 3, e.st == 5});
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; fault = 1'b0; fault_clr = 1'b0;
    update_sel = 1'b0; f_zero = 1'b0; f_period = 1'b0;
    period = 32'd99; duty_target = 32'd40; duty_step = 32'd10;
    car = 1; car_len = 6; m1 = '0; m2 = '0; last1 = 0; last2 = 0;
    @(negedge clk);
    cyc(); cyc();
    chk("reset_outputs", {26'd0, state1, duty1, pwm_on1, running1, fault1}, 64'd0);
    rst = 1'b0;

    // Soft start 0..40 in steps of 10, then ramp down
    rec_clear();
    start = 1'b1; cyc(); start = 1'b0;
    chk("t1_arm", 64'(state1), 64'd1);
    run_until(3, 300, "t1_run");
    chk("t1_running", 64'(running1), 64'd1);
    cmp_seq("t1_seq", 1, '{10, 20, 30, 40}, 4);
    cmp_seq("t1_seq_div2", 2, '{10, 20, 30, 40}, 4);

    rec_clear();
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("t2_ramp_down", 64'(state1), 64'd4);
    run_until(0, 400, "t2_idle");
    chk("t2_pwm_off", 64'(pwm_on1), 64'd0);
    cmp_seq("t2_seq", 1, '{30, 20, 10, 0}, 4);

    // Fault during ramp up at duty 20
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 0; k < 200 && !(m1.st == 2 && m1.duty == 20); k++) cyc();
    chk("t3_at_duty20", 64'(duty1), 64'd20);
    fault = 1'b1; cyc();
    chk("t3_fault_outs", {61'd0, state1 == 3'd5, pwm_on1, duty1 != 0}, {61'd0, 1'b1, 1'b0, 1'b0});
    chk("t3_fault_latched", 64'(fault1), 64'd1);
    fault_clr = 1'b1; cyc(); fault_clr = 1'b0;
    chk("t3_clr_ignored", 64'(state1), 64'd5);
    fault = 1'b0; cyc();
    fault_clr = 1'b1; cyc(); fault_clr = 1'b0;
    chk("t3_cleared", 64'(state1), 64'd0);
    chk("t3_cleared_dut2", 64'(state2), 64'd0);

    // Target clamped to period, then slew down to a lower target
    period = 32'd99; duty_target = 32'd150; duty_step = 32'd60;
    rec_clear();
    start = 1'b1; cyc(); start = 1'b0;
    run_until(3, 300, "t4_run");
    cmp_seq("t4_up", 1, '{60, 99, 0, 0}, 2);
    cmp_seq("t4_up_div2", 2, '{60, 99, 0, 0}, 2);
    rec_clear();
    duty_target = 32'd10;
    for (int k = 0; k < 200 && !(m1.duty == 10 && m2.duty == 10); k++) cyc();
    cmp_seq("t4_down", 1, '{39, 10, 0, 0}, 2);
    cmp_seq("t4_down_div2", 2, '{39, 10, 0, 0}, 2);
    stop = 1'b1; cyc(); stop = 1'b0;
    run_until(0, 400, "t4_idle");

    // Both carrier flags as update events, zero step treated as 1
    update_sel = 1'b1; duty_step = 32'd0; duty_target = 32'd3;
    rec_clear();
    start = 1'b1; cyc(); start = 1'b0;
    run_until(3, 300, "t5_run");
    cmp_seq("t5_seq", 1, '{1, 2, 3, 0}, 3);
    cmp_seq("t5_seq_div2", 2, '{1, 2, 3, 0}, 3);
    stop = 1'b1; cyc(); stop = 1'b0;
    run_until(0, 400, "t5_idle");
    update_sel = 1'b0;

    // start and stop together in IDLE, then asynchronous reset while running
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    chk("t6_start_stop_idle", {61'd0, state1, state2}, 64'd0);
    duty_target = 32'd40; duty_step = 32'd10;
    start = 1'b1; cyc(); start = 1'b0;
    run_until(3, 300, "t6_run");
    rst = 1'b1;
    #1;
    chk("t6_async_rst", {26'd0, state1, duty1, pwm_on1, running1, fault1}, 64'd0);
    chk("t6_async_rst_dut2", {34'd0, state2, 24'd0, duty2, pwm_on2, running2, fault2}, 64'd0);
    cyc();
    rst = 1'b0;

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      start     = ($urandom_range(0, 15) == 0);
      stop      = ($urandom_range(0, 59) == 0);
      fault_clr = ($urandom_range(0, 7) == 0);
      if (fault) fault = ($urandom_range(0, 3) != 0);
      else       fault = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) begin
        period      = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 200));
        duty_target = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 250));
        duty_step   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 50));
        update_sel  = 1'($urandom_range(0, 1));
        car_len     = $urandom_range(3, 8);
      end
      rst = ($urandom_range(0, 499) == 0);
      cyc();
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; fault = 1'b0; fault_clr = 1'b0;

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(q1.size() + q2.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
